// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: state encoding, default
// parameter values and the timer sizing helper.
package frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_WAIT_CAP = 3'd2,
        ST_XFORM    = 3'd3,
        ST_WAIT_XF  = 3'd4,
        ST_HANDOFF  = 3'd5,
        ST_GAP      = 3'd6,
        ST_ERROR    = 3'd7
    } state_e;

    localparam int DEF_FRAME_CNT_W = 8;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_WDOG_CYCLES = 1024;

    // One timer serves both the inter-frame gap and the watchdog, so it must
    // hold the larger of the two reload values.
    function automatic int timer_width(input int gap_cycles, input int wdog_cycles);
        int max_v;
        max_v = (gap_cycles > wdog_cycles) ? gap_cycles : wdog_cycles;
        return (max_v > 0) ? $clog2(max_v + 1) : 1;
    endfunction

endpackage

// File: rtl/frame_scheduler_timer.sv
// Loadable down-counter with zero flag. Load wins over decrement; the
// counter saturates at zero.
module frame_scheduler_timer
    import frame_scheduler_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload, decrement toward zero, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/frame_scheduler.sv
// Frame sequencer: ISI capture -> accelerator transform -> processor handoff,
// single-shot or continuous. Optional watchdog on the two wait states is
// enabled by defining FRAME_SCHED_WDOG_EN; without it the wait states block
// indefinitely and out_error is tied low.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int FRAME_CNT_W = DEF_FRAME_CNT_W,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_start,
    input  logic                   in_continuous,
    input  logic                   in_stop,
    output logic                   out_ISI_start,
    input  logic                   in_ISI_finished,
    output logic                   out_accel_start,
    input  logic                   in_accel_done,
    output logic                   out_result_valid,
    input  logic                   in_proc_ack,
    output logic                   out_busy,
    output logic [FRAME_CNT_W-1:0] out_frame_count,
    output logic [2:0]             out_state,
    output logic                   out_error
);

    localparam int TMR_W = timer_width(GAP_CYCLES, WDOG_CYCLES);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef FRAME_SCHED_WDOG_EN
    localparam logic [TMR_W-1:0] WDOG_LOAD = TMR_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);
`endif

    state_e                 state_q, state_d;
    logic                   stop_pend_q, stop_pend_d;
    logic [FRAME_CNT_W-1:0] count_q, count_d;
    logic                   isi_start_q, isi_start_d;
    logic                   accel_start_q, accel_start_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    logic                   tmr_load_s;
    logic [TMR_W-1:0]       tmr_val_s;
    logic                   tmr_dec_s;
    logic                   tmr_zero_s;

    frame_scheduler_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (in_clk),
        .rst_ni     (in_rst),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .dec_i      (tmr_dec_s),
        .zero_o     (tmr_zero_s)
    );

    // Next-state, frame counter, stop latch and timer control.
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        count_d     = count_q;
        tmr_load_s  = 1'b0;
        tmr_val_s   = GAP_LOAD;
        tmr_dec_s   = 1'b0;

        // A stop request mid-frame lets the frame complete, then parks in IDLE.
        if (in_stop && (state_q != ST_IDLE) && (state_q != ST_ERROR)) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                // Done inputs are not looked at here so a level left high
                // from the previous frame cannot short-circuit the wait.
                state_d = ST_WAIT_CAP;
`ifdef FRAME_SCHED_WDOG_EN
                tmr_load_s = 1'b1;
                tmr_val_s  = WDOG_LOAD;
`endif
            end
            ST_WAIT_CAP: begin
                if (in_ISI_finished) begin
                    state_d = ST_XFORM;
                end else begin
`ifdef FRAME_SCHED_WDOG_EN
                    if (tmr_zero_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        tmr_dec_s = 1'b1;
                    end
`else
                    state_d = ST_WAIT_CAP;
`endif
                end
            end
            ST_XFORM: begin
                state_d = ST_WAIT_XF;
`ifdef FRAME_SCHED_WDOG_EN
                tmr_load_s = 1'b1;
                tmr_val_s  = WDOG_LOAD;
`endif
            end
            ST_WAIT_XF: begin
                if (in_accel_done) begin
                    state_d = ST_HANDOFF;
                    count_d = count_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
                end else begin
`ifdef FRAME_SCHED_WDOG_EN
                    if (tmr_zero_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        tmr_dec_s = 1'b1;
                    end
`else
                    state_d = ST_WAIT_XF;
`endif
                end
            end
            ST_HANDOFF: begin
                if (in_proc_ack) begin
                    // Loop only if no stop arrived earlier or in this cycle.
                    if (in_continuous && !stop_pend_q && !in_stop) begin
                        if (GAP_CYCLES > 0) begin
                            state_d    = ST_GAP;
                            tmr_load_s = 1'b1;
                            tmr_val_s  = GAP_LOAD;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HANDOFF;
                end
            end
            ST_GAP: begin
                if (in_stop) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero_s) begin
                    state_d = ST_CAPTURE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            ST_ERROR: begin
`ifdef FRAME_SCHED_WDOG_EN
                if (in_stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERROR;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) begin
            stop_pend_d = 1'b0;
        end else begin
            stop_pend_d = stop_pend_d;
        end
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        isi_start_d   = (state_d == ST_CAPTURE);
        accel_start_d = (state_d == ST_XFORM);
        valid_d       = (state_d == ST_HANDOFF);
        busy_d        = (state_d != ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q       <= ST_IDLE;
            stop_pend_q   <= 1'b0;
            count_q       <= {FRAME_CNT_W{1'b0}};
            isi_start_q   <= 1'b0;
            accel_start_q <= 1'b0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stop_pend_q   <= stop_pend_d;
            count_q       <= count_d;
            isi_start_q   <= isi_start_d;
            accel_start_q <= accel_start_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
        end
    end

`ifdef FRAME_SCHED_WDOG_EN
    logic error_q;
    logic error_d;

    // Error flag tracks residence in ERROR; leaving via stop clears it.
    always_comb begin
        error_d = (state_d == ST_ERROR);
    end

    // Error flag register.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign out_error = error_q;
`else
    assign out_error = 1'b0;
`endif

    assign out_ISI_start    = isi_start_q;
    assign out_accel_start  = accel_start_q;
    assign out_result_valid = valid_q;
    assign out_busy         = busy_q;
    assign out_frame_count  = count_q;
    assign out_state        = state_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: stimulus pushes expected pulse
// edges into queues, a negedge monitor pops and compares them.
module tb_frame_scheduler;

    localparam int CW = 2;

    logic          in_clk = 1'b0;
    logic          in_rst = 1'b0;
    logic          in_start = 1'b0;
    logic          in_continuous = 1'b0;
    logic          in_stop = 1'b0;
    logic          out_ISI_start;
    logic          in_ISI_finished = 1'b0;
    logic          out_accel_start;
    logic          in_accel_done = 1'b0;
    logic          out_result_valid;
    logic          in_proc_ack = 1'b0;
    logic          out_busy;
    logic [CW-1:0] out_frame_count;
    logic [2:0]    out_state;
    logic          out_error;

    frame_scheduler #(
        .FRAME_CNT_W (CW),
        .GAP_CYCLES  (4),
        .WDOG_CYCLES (16)
    ) dut (
        .in_clk           (in_clk),
        .in_rst           (in_rst),
        .in_start         (in_start),
        .in_continuous    (in_continuous),
        .in_stop          (in_stop),
        .out_ISI_start    (out_ISI_start),
        .in_ISI_finished  (in_ISI_finished),
        .out_accel_start  (out_accel_start),
        .in_accel_done    (in_accel_done),
        .out_result_valid (out_result_valid),
        .in_proc_ack      (in_proc_ack),
        .out_busy         (out_busy),
        .out_frame_count  (out_frame_count),
        .out_state        (out_state),
        .out_error        (out_error)
    );

    typedef struct {
        int when;
        int cnt;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   exp_cnt = 0;
    int   isi_q[$];
    int   acc_q[$];
    res_t res_q[$];
    int   wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial forever #5 in_clk = ~in_clk;

    always @(posedge in_clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_start();
        isi_q.push_back(edge_cnt + 1);
        in_start = 1'b1;
        step();
        in_start = 1'b0;
    endtask

    task automatic finish_cap();
        acc_q.push_back(edge_cnt + 1);
        in_ISI_finished = 1'b1;
        step();
        in_ISI_finished = 1'b0;
    endtask

    task automatic finish_xf();
        res_t r;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        r.when = edge_cnt + 1;
        r.cnt  = exp_cnt;
        res_q.push_back(r);
        in_accel_done = 1'b1;
        step();
        in_accel_done = 1'b0;
    endtask

    // Ack at the next edge; if another frame follows, its ISI pulse lands
    // 4 gap cycles later.
    task automatic do_ack(input bit with_stop, input bit expect_next);
        if (expect_next) isi_q.push_back(edge_cnt + 1 + 4);
        in_proc_ack = 1'b1;
        in_stop     = with_stop;
        step();
        in_proc_ack = 1'b0;
        in_stop     = 1'b0;
    endtask

    // From just after CAPTURE entry up to the edge before the ack.
    task automatic single_body();
        idle(2);
        finish_cap();
        idle(2);
        finish_xf();
        idle(1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, out_state, 0);
        chk({tag, "_busy"}, out_busy, 0);
        chk({tag, "_valid"}, out_result_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_isi"}, out_ISI_start, 0);
        chk({tag, "_accel"}, out_accel_start, 0);
        chk({tag, "_count"}, out_frame_count, 0);
        chk({tag, "_error"}, out_error, 0);
        check_idle(tag);
    endtask

    task automatic apply_reset();
        in_start = 1'b0; in_continuous = 1'b0; in_stop = 1'b0;
        in_ISI_finished = 1'b0; in_accel_done = 1'b0; in_proc_ack = 1'b0;
        #1 in_rst = 1'b0;
        #1;
        check_all_zero("reset");
        step();
        step();
        in_rst  = 1'b1;
        exp_cnt = 0;
    endtask

    // Monitor: every pulse / valid rise must match the head of its queue.
    initial begin
        bit   prev_v;
        int   e;
        res_t r;
        prev_v = 1'b0;
        forever begin
            @(negedge in_clk);
            if (out_ISI_start) begin
                if (isi_q.size() == 0) chk("isi_unexpected", 1, 0);
                else begin e = isi_q.pop_front(); chk("isi_edge", edge_cnt, e); end
            end
            if (out_accel_start) begin
                if (acc_q.size() == 0) chk("accel_unexpected", 1, 0);
                else begin e = acc_q.pop_front(); chk("accel_edge", edge_cnt, e); end
            end
            if (out_result_valid && !prev_v) begin
                if (res_q.size() == 0) chk("valid_unexpected", 1, 0);
                else begin
                    r = res_q.pop_front();
                    chk("valid_edge", edge_cnt, r.when);
                    chk("valid_count", out_frame_count, r.cnt);
                end
            end
            prev_v = out_result_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: actual running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: single frame with ignored start/ack outside their states
        apply_reset();
        do_start();
        idle(2);
        in_start = 1'b1; step(); in_start = 1'b0;
        idle(1);
        finish_cap();
        idle(3);
        in_proc_ack = 1'b1; step(); in_proc_ack = 1'b0;
        idle(2);
        finish_xf();
        idle(2);
        chk("t1_valid_held", out_result_valid, 1);
        chk("t1_state_handoff", out_state, 5);
        do_ack(1'b0, 1'b0);
        check_idle("t1");
        chk("t1_count", out_frame_count, 1);

        // 3: stale ISI_finished level held through the new start
        in_ISI_finished = 1'b1;
        idle(1);
        do_start();
        acc_q.push_back(edge_cnt + 2);
        idle(2);
        in_ISI_finished = 1'b0;
        idle(2);
        finish_xf();
        idle(1);
        do_ack(1'b0, 1'b0);
        check_idle("t3");
        chk("t3_count", out_frame_count, 2);

        // 4: async reset in WAIT_XF, late accel_done must not produce valid
        do_start();
        idle(2);
        finish_cap();
        idle(2);
        chk("t4_state_wait_xf", out_state, 4);
        #2 in_rst = 1'b0;
        #1;
        check_all_zero("t4_async");
        in_rst  = 1'b1;
        exp_cnt = 0;
        in_accel_done = 1'b1;
        idle(3);
        in_accel_done = 1'b0;
        check_idle("t4_after");

        // 2: continuous, three frames, stop during the third
        apply_reset();
        in_continuous = 1'b1;
        do_start();
        for (int f = 1; f <= 3; f++) begin
            idle(2);
            finish_cap();
            if (f == 3) begin in_stop = 1'b1; step(); in_stop = 1'b0; end
            else idle(1);
            idle(1);
            finish_xf();
            idle(1);
            do_ack(1'b0, f < 3);
            if (f < 3) idle(4);
        end
        check_idle("t2");
        chk("t2_count", out_frame_count, 3);
        idle(6);
        chk("t2_stays_idle", out_state, 0);

        // 2b: stop during GAP returns to IDLE on the next edge
        do_start();
        single_body();
        do_ack(1'b0, 1'b0);
        chk("t2b_gap", out_state, 6);
        idle(1);
        in_stop = 1'b1; step(); in_stop = 1'b0;
        check_idle("t2b");
        chk("t2b_count", out_frame_count, 0);
        idle(6);

        // 2c: ack and stop together in continuous mode -> IDLE
        do_start();
        single_body();
        do_ack(1'b1, 1'b0);
        check_idle("t2c");
        idle(6);
        in_continuous = 1'b0;

        // 5: counter wrap with a 2-bit counter
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_start();
            single_body();
            do_ack(1'b0, 1'b0);
            chk("t5_count", out_frame_count, wrap_exp[i]);
            idle(1);
        end

        // 6: missing ISI_finished
        apply_reset();
        do_start();
`ifdef FRAME_SCHED_WDOG_EN
        idle(16);
        chk("t6_error_not_yet", out_error, 0);
        idle(1);
        chk("t6_error_set", out_error, 1);
        chk("t6_state_error", out_state, 7);
        in_start = 1'b1; step(); in_start = 1'b0;
        chk("t6_start_ignored", out_state, 7);
        in_stop = 1'b1; step(); in_stop = 1'b0;
        chk("t6_stop_idle", out_state, 0);
        chk("t6_error_clear", out_error, 0);
`else
        idle(40);
        chk("t6_still_wait_cap", out_state, 2);
        chk("t6_no_error", out_error, 0);
`endif
        apply_reset();
        idle(2);

        chk("isi_queue_empty", isi_q.size(), 0);
        chk("accel_queue_empty", acc_q.size(), 0);
        chk("result_queue_empty", res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
